vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen_if.sv | 34 +++
 rtl/vga_sync_gen.sv | 117 +++++++++++
 tb/tb_vga_sync_gen.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: scan position, sync and strobe bundle.
// master drives x/y, hsync/vsync, video_on, p_tick, line/frame end.
interface vga_sync_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       line_end;
  logic       frame_end;

  modport master (
    output x,
    output y,
    output hsync,
    output vsync,
    output video_on,
    output p_tick,
    output line_end,
    output frame_end
  );

  modport slave (
    input x,
    input y,
    input hsync,
    input vsync,
    input video_on,
    input p_tick,
    input line_end,
    input frame_end
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel timing (clk divider, h/v scan, syncs).
// Ports: clk, reset (async, active-high), vga (master bundle).
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);

  localparam logic [9:0] HS_LO =
    10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI =
    10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO =
    10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI =
    10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic [9:0]       x_d;
  logic [9:0]       y_d;
  logic             hsync_q;
  logic             vsync_q;
  logic             vis_q;
  logic             hsync_d;
  logic             vsync_d;
  logic             vis_d;
  logic             tick;
  logic             h_last;
  logic             v_last;

  assign tick   = (div_cnt == DIV_LAST);
  assign h_last = (x_q == H_LAST);
  assign v_last = (y_q == V_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      x_d = h_last ? '0 : x_q + 10'd1;
      if (h_last) begin
        y_d = v_last ? '0 : y_q + 10'd1;
      end
    end
  end

  // Flags are decoded from the next counts so the
  // registered copies line up with the x/y shown.
  always_comb begin
    hsync_d = !((x_d >= HS_LO) && (x_d < HS_HI));
    vsync_d = !((y_d >= VS_LO) && (y_d < VS_HI));
    vis_d   = (x_d < H_VIS) && (y_d < V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      vis_q   <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vis_q   <= vis_d;
    end
  end

  assign vga.x         = x_q;
  assign vga.y         = y_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.video_on  = vis_q;
  assign vga.p_tick    = tick;
  assign vga.line_end  = tick & h_last;
  assign vga.frame_end = tick & h_last & v_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: vectors, corner sequences and random resets
// against an arithmetic model of the scan position.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       le;
    logic       fe;
  } obs_t;

  typedef struct {
    int   n;
    obs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic rst_c;

  always #5 clk = ~clk;

  vga_sync_gen_if bus_a ();
  vga_sync_gen_if bus_b ();
  vga_sync_gen_if bus_c ();

  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (bus_a)
  );

  vga_sync_gen #(
    .CLK_DIV(4), .H_DISPLAY(20), .H_FRONT(3),
    .H_SYNC(5), .H_BACK(4), .V_DISPLAY(12),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (bus_b)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(20), .H_FRONT(3),
    .H_SYNC(5), .H_BACK(4), .V_DISPLAY(12),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_c (
    .clk   (clk),
    .reset (rst_c),
    .vga   (bus_c)
  );

  obs_t oa, ob, oc;
  assign oa = {bus_a.x, bus_a.y, bus_a.hsync,
               bus_a.vsync, bus_a.video_on,
               bus_a.p_tick, bus_a.line_end,
               bus_a.frame_end};
  assign ob = {bus_b.x, bus_b.y, bus_b.hsync,
               bus_b.vsync, bus_b.video_on,
               bus_b.p_tick, bus_b.line_end,
               bus_b.frame_end};
  assign oc = {bus_c.x, bus_c.y, bus_c.hsync,
               bus_c.vsync, bus_c.video_on,
               bus_c.p_tick, bus_c.line_end,
               bus_c.frame_end};

  // Clock edges seen since each reset was released.
  int na, nb, nc;
  always @(posedge clk or posedge rst_a)
    if (rst_a) na <= 0; else na <= na + 1;
  always @(posedge clk or posedge rst_b)
    if (rst_b) nb <= 0; else nb <= nb + 1;
  always @(posedge clk or posedge rst_c)
    if (rst_c) nc <= 0; else nc <= nc + 1;

  int checks = 0;
  int errors = 0;

  function automatic obs_t mk(
    int x, int y, bit hs, bit vs,
    bit vo, bit pt, bit le, bit fe);
    obs_t o;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.hs = hs;
    o.vs = vs;
    o.vo = vo;
    o.pt = pt;
    o.le = le;
    o.fe = fe;
    return o;
  endfunction

  // Position follows directly from elapsed clocks.
  function automatic obs_t model(
    int n, int dv, int hd, int hf, int hw, int hb,
    int vd, int vf, int vw, int vb);
    int ht, vt, p, xi, yi;
    bit pt, le, fe;
    ht = hd + hf + hw + hb;
    vt = vd + vf + vw + vb;
    p  = n / dv;
    xi = p % ht;
    yi = (p / ht) % vt;
    pt = ((n % dv) == dv - 1);
    le = pt && (xi == ht - 1);
    fe = le && (yi == vt - 1);
    return mk(xi, yi,
      !(xi >= hd + hf && xi < hd + hf + hw),
      !(yi >= vd + vf && yi < vd + vf + vw),
      (xi < hd) && (yi < vd), pt, le, fe);
  endfunction

  function automatic obs_t ma(int n);
    return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic obs_t mb(int n);
    return model(n, 4, 20, 3, 5, 4, 12, 2, 2, 3);
  endfunction
  function automatic obs_t mc(int n);
    return model(n, 1, 20, 3, 5, 4, 12, 2, 2, 3);
  endfunction

  task automatic chk(string nm, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display({"FAIL %s: got x=%0d y=%0d hs=%b vs=%b",
        " vo=%b pt=%b le=%b fe=%b; want x=%0d y=%0d",
        " hs=%b vs=%b vo=%b pt=%b le=%b fe=%b"},
        nm, a.x, a.y, a.hs, a.vs, a.vo, a.pt, a.le,
        a.fe, e.x, e.y, e.hs, e.vs, e.vo, e.pt,
        e.le, e.fe);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  vec_t tab[$];
  obs_t rst4, rst1;
  int   found, per, le_n, fe_n, vs_lo, vo_n;
  int   vo_bad, rng_bad, pt_low, x_bad;
  int   le_t0, le_t1, fe_t0, fe_t1, len;
  int   px;
  logic [2:0] sel;

  initial begin
    rst4 = mk(0, 0, 1, 1, 1, 0, 0, 0);
    rst1 = mk(0, 0, 1, 1, 1, 1, 0, 0);

    tab.push_back('{0,    mk(0,   0, 1, 1, 1, 0, 0, 0)});
    tab.push_back('{2,    mk(0,   0, 1, 1, 1, 0, 0, 0)});
    tab.push_back('{3,    mk(0,   0, 1, 1, 1, 1, 0, 0)});
    tab.push_back('{4,    mk(1,   0, 1, 1, 1, 0, 0, 0)});
    tab.push_back('{7,    mk(1,   0, 1, 1, 1, 1, 0, 0)});
    tab.push_back('{8,    mk(2,   0, 1, 1, 1, 0, 0, 0)});
    tab.push_back('{2556, mk(639, 0, 1, 1, 1, 0, 0, 0)});
    tab.push_back('{2560, mk(640, 0, 1, 1, 0, 0, 0, 0)});
    tab.push_back('{2620, mk(655, 0, 1, 1, 0, 0, 0, 0)});
    tab.push_back('{2624, mk(656, 0, 0, 1, 0, 0, 0, 0)});
    tab.push_back('{3004, mk(751, 0, 0, 1, 0, 0, 0, 0)});
    tab.push_back('{3008, mk(752, 0, 1, 1, 0, 0, 0, 0)});
    tab.push_back('{3199, mk(799, 0, 1, 1, 0, 1, 1, 0)});
    tab.push_back('{3200, mk(0,   1, 1, 1, 1, 0, 0, 0)});
    tab.push_back('{6399, mk(799, 1, 1, 1, 0, 1, 1, 0)});
    tab.push_back('{6400, mk(0,   2, 1, 1, 1, 0, 0, 0)});

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a", oa, rst4);
    chk("reset_b", ob, rst4);
    chk("reset_c", oc, rst1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      while (na < tab[i].n) @(negedge clk);
      chk($sformatf("tab_a_%0d", tab[i].n), oa, tab[i].e);
    end

    // Asynchronous reset in the middle of a line.
    repeat ($urandom_range(200, 1)) @(negedge clk);
    #2 rst_a = 1'b1;
    #1 chk("reset_mid_a", oa, rst4);
    @(negedge clk);
    rst_a = 1'b0;

    // Frame wrap and frame-level statistics.
    found = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (ob.fe) begin
        found = 1;
        break;
      end
    end
    chk_int("fe_b_seen", found, 1);
    chk("fe_b_pos", ob, mk(31, 18, 1, 1, 0, 1, 1, 1));
    per = 0; le_n = 0; fe_n = 0; vs_lo = 0;
    vo_n = 0; vo_bad = 0; rng_bad = 0;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge clk);
      if (t == 1) chk("wrap_b", ob, rst4);
      if (ob.le) le_n++;
      if (ob.fe) fe_n++;
      if (!ob.vs) vs_lo++;
      if (ob.vo) vo_n++;
      if (ob.vo && ob.y >= 12) vo_bad++;
      if (ob.x > 31 || ob.y > 18) rng_bad++;
      if (ob.fe) begin
        per = t;
        break;
      end
    end
    chk_int("frame_period_b", per, 2432);
    chk_int("line_ends_b", le_n, 19);
    chk_int("frame_ends_b", fe_n, 1);
    chk_int("vsync_low_clks_b", vs_lo, 256);
    chk_int("video_on_clks_b", vo_n, 960);
    chk_int("video_on_blank_b", vo_bad, 0);
    chk_int("range_b", rng_bad, 0);

    // Reset while both syncs are low, on a tick cycle.
    found = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (ob.x == 25 && ob.y == 15 && ob.pt) begin
        found = 1;
        break;
      end
    end
    chk_int("midsync_b_seen", found, 1);
    chk("midsync_b", ob, mk(25, 15, 0, 0, 0, 1, 0, 0));
    #2 rst_b = 1'b1;
    #1 chk("midrst_b", ob, rst4);
    @(negedge clk);
    rst_b = 1'b0;
    found = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (ob.pt) begin
        found = 1;
        break;
      end
    end
    chk_int("restart_tick_b", nb, 3);
    chk("restart_b3", ob, mk(0, 0, 1, 1, 1, 1, 0, 0));
    @(negedge clk);
    chk("restart_b4", ob, mk(1, 0, 1, 1, 1, 0, 0, 0));

    // Undivided instance: one pixel per clock.
    pt_low = 0; x_bad = 0;
    le_t0 = -1; le_t1 = -1; fe_t0 = -1; fe_t1 = -1;
    px = oc.x;
    for (int t = 0; t < 1300; t++) begin
      @(negedge clk);
      if (!oc.pt) pt_low++;
      if (oc.x != (px + 1) % 32) x_bad++;
      px = oc.x;
      if (oc.le) begin
        if (le_t0 < 0) le_t0 = nc;
        else if (le_t1 < 0) le_t1 = nc;
      end
      if (oc.fe) begin
        if (fe_t0 < 0) fe_t0 = nc;
        else if (fe_t1 < 0) fe_t1 = nc;
      end
    end
    chk_int("ptick_const_c", pt_low, 0);
    chk_int("x_step_c", x_bad, 0);
    chk_int("line_period_c", le_t1 - le_t0, 32);
    chk_int("frame_period_c", fe_t1 - fe_t0, 608);

    // Random run lengths and reset pulses vs. the model.
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1500, 50);
      repeat (len) begin
        @(negedge clk);
        chk("rand_a", oa, ma(na));
        chk("rand_b", ob, mb(nb));
        chk("rand_c", oc, mc(nc));
      end
      sel = 3'($urandom_range(7, 1));
      #($urandom_range(4, 1));
      if (sel[0]) rst_a = 1'b1;
      if (sel[1]) rst_b = 1'b1;
      if (sel[2]) rst_c = 1'b1;
      #1;
      if (sel[0]) chk("rand_rst_a", oa, rst4);
      if (sel[1]) chk("rand_rst_b", ob, rst4);
      if (sel[2]) chk("rand_rst_c", oc, rst1);
      repeat ($urandom_range(2, 0)) @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
